// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between icache and dcache,
// with grant lock until accept and an in-order ID queue to route read responses back.
module mem_arbiter #(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128,
   parameter int MAX_OUT   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ic_req_valid,
   output logic                   ic_req_ready,
   input  logic [ADDR_BITS-1:0]   ic_req_addr,
   input  logic                   ic_req_rw,
   input  logic                   ic_req_data_valid,
   output logic                   ic_req_data_ready,
   input  logic [DATA_BITS-1:0]   ic_req_data_bits,
   input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
   output logic                   ic_resp_valid,
   output logic [DATA_BITS-1:0]   ic_resp_data,
   input  logic                   dc_req_valid,
   output logic                   dc_req_ready,
   input  logic [ADDR_BITS-1:0]   dc_req_addr,
   input  logic                   dc_req_rw,
   input  logic                   dc_req_data_valid,
   output logic                   dc_req_data_ready,
   input  logic [DATA_BITS-1:0]   dc_req_data_bits,
   input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
   output logic                   dc_resp_valid,
   output logic [DATA_BITS-1:0]   dc_resp_data,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_valid,
   input  logic [DATA_BITS-1:0]   mem_resp_data,
   output logic                   resp_err
);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW = $clog2(MAX_OUT) + 1;
   logic               last, lock, own_q, sel, room, ic_ok, dc_ok, accept, push, pop;
   logic [MAX_OUT-1:0] ids;
   logic [PW-1:0]      wptr, rptr;
   logic [CW-1:0]      cnt;
   // a response arriving this cycle frees a slot, so a full queue can still take a read
   always_comb begin
      room               = (cnt != CW'(MAX_OUT)) || mem_resp_valid;
      ic_ok              = ic_req_valid && (ic_req_rw || room);
      dc_ok              = dc_req_valid && (dc_req_rw || room);
      sel                = lock ? own_q : (ic_ok && dc_ok) ? !last : dc_ok;
      mem_req_valid      = !reset && (sel ? dc_ok : ic_ok);
      mem_req_addr       = sel ? dc_req_addr : ic_req_addr;
      mem_req_rw         = sel ? dc_req_rw : ic_req_rw;
      mem_req_data_valid = !reset && (sel ? dc_req_data_valid : ic_req_data_valid);
      mem_req_data_bits  = sel ? dc_req_data_bits : ic_req_data_bits;
      mem_req_data_mask  = sel ? dc_req_data_mask : ic_req_data_mask;
      accept             = mem_req_valid && mem_req_ready &&
                           (!mem_req_rw || (mem_req_data_valid && mem_req_data_ready));
      push               = accept && !mem_req_rw;
      pop                = !reset && mem_resp_valid && (cnt != '0);
      ic_req_ready       = accept && !sel;
      ic_req_data_ready  = accept && !sel;
      dc_req_ready       = accept && sel;
      dc_req_data_ready  = accept && sel;
      ic_resp_valid      = pop && !ids[rptr];
      dc_resp_valid      = pop && ids[rptr];
      ic_resp_data       = mem_resp_data;
      dc_resp_data       = mem_resp_data;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         last     <= 1'b1;
         lock     <= 1'b0;
         own_q    <= 1'b0;
         ids      <= '0;
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
         resp_err <= 1'b0;
      end else begin
         if (accept) begin
            lock <= 1'b0;
            last <= sel;
         end else if (mem_req_valid) begin
            lock  <= 1'b1;
            own_q <= sel;
         end
         if (push) begin
            ids[wptr] <= sel;
            wptr      <= (wptr == PW'(MAX_OUT - 1)) ? '0 : wptr + 1'b1;
         end
         if (pop) rptr <= (rptr == PW'(MAX_OUT - 1)) ? '0 : rptr + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);
         if (mem_resp_valid && cnt == '0) resp_err <= 1'b1;
      end
   end
endmodule
